// File: rtl/pl_cpu_pkg.sv
// Shared PL_CPU pipeline definitions.
//   state_t  : hazard sequencer state encoding (visible on the state port)
//   REG_W    : architectural register index width
//   IFID_W / IFID_NOP : IF/ID pipeline word width and its all-zero NOP value
package pl_cpu_pkg;

  localparam int REG_W  = 5;
  localparam int IFID_W = 96;
  localparam logic [IFID_W-1:0] IFID_NOP = '0;

  // Fill and branch-extra counts both fit in 4 bits (max 15).
  localparam int SEQ_W = 4;

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bus: ID/EX/MEM hazard inputs and pipeline control outputs.
//   master : pipeline side, drives hazard inputs, observes controls
//   slave  : hazard controller
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  import pl_cpu_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd;
  logic             ex_branch_taken;
  logic             mem_busy;

  logic             pc_we;
  logic             ifid_E;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_E;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd, ex_branch_taken, mem_busy,
    input  pc_we, ifid_E, ifid_flush, idex_bubble, exmem_E, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd, ex_branch_taken, mem_busy,
    output pc_we, ifid_E, ifid_flush, idex_bubble, exmem_E, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter.
//   Clk, Rst_n : clock, async active-low reset (clears count)
//   clear      : synchronous clear
//   inc        : count one event this cycle
//   count_o    : current count, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                               cnt_q <= '0;
    else if (clear)                           cnt_q <= '0;
    else if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign count_o = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage PL_CPU pipeline.
//   Clk, Rst_n : clock, async active-low reset
//   hz         : hazard inputs (load-use operands, branch, mem_busy) and
//                pipeline controls (pc_we, ifid_E/flush, idex_bubble,
//                exmem_E), FSM state and saturating stall/flush statistics.
// Controls are combinational from the registered state and current inputs.
module pipe_hazard_ctrl
  import pl_cpu_pkg::*;
#(
  parameter int FILL_CYCLES = 1,
  parameter int BR_EXTRA    = 1,
  parameter int CNT_W       = 16
) (
  input  logic Clk,
  input  logic Rst_n,
  pipe_hazard_ctrl_if.slave hz
);
  state_t           state_q, state_d;
  logic [SEQ_W-1:0] cnt_q, cnt_d;
  logic             load_use, stall_inc, flush_inc;
  logic             pc_we, ifid_E, ifid_flush, idex_bubble, exmem_E;

  assign load_use = hz.ex_mem_read && (hz.ex_rd != '0) &&
                    ((hz.ex_rd == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rd == hz.id_rt)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    pc_we       = 1'b1;
    ifid_E      = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_E     = 1'b1;
    case (state_q)
      ST_FILL: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        cnt_d       = cnt_q - SEQ_W'(1);
        if (cnt_q <= SEQ_W'(1)) state_d = ST_RUN;
      end
      ST_FLUSH: begin
        if (hz.mem_busy) begin
          // Freeze; remaining flush count holds until memory is ready.
          pc_we   = 1'b0;
          ifid_E  = 1'b0;
          exmem_E = 1'b0;
        end else begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          cnt_d       = cnt_q - SEQ_W'(1);
          if (cnt_q <= SEQ_W'(1)) state_d = ST_RUN;
        end
      end
      default: begin
        // RUN and MEM_WAIT share one decision: MEM_WAIT only records that
        // the previous cycle was frozen; once memory frees it acts as RUN.
        state_d = ST_RUN;
        if (hz.mem_busy) begin
          pc_we   = 1'b0;
          ifid_E  = 1'b0;
          exmem_E = 1'b0;
          state_d = ST_MEM_WAIT;
        end else if (hz.ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_inc   = 1'b1;
          if (BR_EXTRA > 0) begin
            state_d = ST_FLUSH;
            cnt_d   = SEQ_W'(BR_EXTRA);
          end
        end else if (load_use) begin
          // One bubble suffices: the load moves on to MEM this cycle.
          pc_we       = 1'b0;
          ifid_E      = 1'b0;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
        end
      end
    endcase
    if (!Rst_n) begin
      pc_we       = 1'b0;
      ifid_E      = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_E     = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_FILL;
      cnt_q   <= SEQ_W'(FILL_CYCLES);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clk(Clk), .Rst_n(Rst_n), .clear(1'b0), .inc(stall_inc), .count_o(hz.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .Clk(Clk), .Rst_n(Rst_n), .clear(1'b0), .inc(flush_inc), .count_o(hz.flush_cnt)
  );

  assign hz.pc_we       = pc_we;
  assign hz.ifid_E      = ifid_E;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.exmem_E     = exmem_E;
  assign hz.state       = state_q;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage PL_CPU pipeline. It drives PC write-enable, the IF/ID register enable and flush, the ID/EX bubble and the EX/MEM enable. It detects load-use hazards, handles taken-branch flushes and freezes the pipe while data memory is busy. It also owns the post-reset fill period, which zeroes IF/ID until the first valid fetch, and keeps saturating stall and flush statistics counters.

Parameters:
FILL_CYCLES, 1, cycles after reset release during which IF/ID is held flushed (range 1..15)
BR_EXTRA, 1, extra bubble cycles after a taken branch, beyond the flush cycle (range 0..7)
CNT_W, 16, width of the statistics counters

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous active-low reset
id_rs  input  5  source register 1 of the instruction in ID
id_rt  input  5  source register 2 of the instruction in ID
id_uses_rt  input  1  ID instruction reads rt
ex_mem_read  input  1  instruction in EX is a load
ex_rd  input  5  destination register of the EX instruction
ex_branch_taken  input  1  branch resolved taken in EX this cycle
mem_busy  input  1  data memory not ready; the MEM stage must hold
pc_we  output  1  PC load enable
ifid_E  output  1  IF/ID enable
ifid_flush  output  1  IF/ID loads zero (NOP)
idex_bubble  output  1  ID/EX loads zero control
exmem_E  output  1  EX/MEM enable
state  output  2  FSM state (FILL=0, RUN=1, MEM_WAIT=2, FLUSH=3)
stall_cnt  output  CNT_W  load-use stall cycles, saturating
flush_cnt  output  CNT_W  taken-branch flush events, saturating

Behaviour:
- Reset (Rst_n=0, async):
  - state=FILL; fill/branch counter loaded with FILL_CYCLES.
  - stall_cnt=0, flush_cnt=0.
  - Outputs while in reset: pc_we=0, ifid_E=0, ifid_flush=1, idex_bubble=1, exmem_E=0.
- Outputs are combinational from state and inputs; state and counters are registered.
- load_use = ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
- FILL:
  - Outputs: pc_we=1, ifid_E=1, ifid_flush=1, idex_bubble=1, exmem_E=1.
  - The counter decrements each cycle; at 1 -> RUN.
  - Inputs other than Rst_n are ignored.
  - Effect: first fetched instruction enters ID exactly FILL_CYCLES+1 cycles after reset release.
- RUN, evaluated in priority order:
  1. mem_busy: all enables 0, ifid_flush=0, idex_bubble=0 (full freeze). Next state MEM_WAIT. A branch or load-use seen in the same cycle is not acted on and not counted; it is re-evaluated after the freeze.
  2. ex_branch_taken: pc_we=1, ifid_E=1, ifid_flush=1, idex_bubble=1, exmem_E=1; flush_cnt+1. If BR_EXTRA>0 -> FLUSH with counter=BR_EXTRA, else stay RUN. Branch has priority over a simultaneous load_use, which is neither stalled nor counted.
  3. load_use: pc_we=0, ifid_E=0, idex_bubble=1, exmem_E=1, ifid_flush=0; stall_cnt+1. Stay RUN; exactly one stall cycle per hazard because the load advances to MEM.
  4. Otherwise: pc_we=ifid_E=exmem_E=1, flush/bubble=0.
- MEM_WAIT:
  - Freeze outputs as in RUN case 1 while mem_busy=1.
  - When mem_busy=0: behave exactly as RUN for that cycle, including hazard priority, and transition from that cycle's decision.
- FLUSH:
  - Outputs: pc_we=1, ifid_E=1, ifid_flush=1, idex_bubble=1, exmem_E=1.
  - Counter decrements; at 1 -> RUN.
  - mem_busy in FLUSH: freeze outputs, counter holds, state stays FLUSH.
  - ex_branch_taken in FLUSH is ignored; the flushed instruction cannot be a branch.
- Counters saturate at 2^CNT_W-1; no wrap.
- Reset asserted mid-stall or mid-flush returns to FILL immediately; counters clear.
- ex_rd==0 never causes a stall.

Decomposition:
- Shared package pl_cpu_pkg:
  - state encoding constants (ST_FILL, ST_RUN, ST_MEM_WAIT, ST_FLUSH)
  - register-index width (5)
  - NOP/zero constant for the 96-bit IF/ID word
- One sub-module, sat_counter (CNT_W, inc, clear), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset release, FILL_CYCLES=1, no hazards -> cycle 0 after release: ifid_flush=1, pc_we=1; cycle 1: state=RUN, all enables 1, flush=0.
- ex_mem_read=1, ex_rd=5, id_rs=5 for one cycle -> pc_we=0, ifid_E=0, idex_bubble=1 for exactly 1 cycle; stall_cnt=1. Same stimulus with ex_rd=0 -> no stall.
- ex_branch_taken=1 with BR_EXTRA=1 -> two consecutive cycles of ifid_flush=1, idex_bubble=1, pc_we=1; flush_cnt=1; then RUN.
- mem_busy=1 for 3 cycles, with load_use true in the first cycle -> all enables 0 for 3 cycles, stall_cnt unchanged. On release, one load-use stall is applied, then normal flow.
- Simultaneous ex_branch_taken=1 and load_use=1 -> flush taken, flush_cnt=1, stall_cnt=0.
- Force stall_cnt to 16'hFFFF, then another load-use -> stall_cnt stays 16'hFFFF. Rst_n pulsed low mid-FLUSH -> state=0 and counters=0 asynchronously, before the next clock edge.
